mmio_lcl_sequencer: RTL and testbench

Host-side front end of the MMIO AXI-Lite master path: accepts 4-byte or 8-byte MMIO requests over a valid/ready channel. Each request becomes one or two 32-bit local-bus accesses (lcl_mmio_wr/rd pulses), handed to the downstream AXI-Lite shim. The block collects that shim's ack/dv and status, then returns one merged response to the host with error and timeout handling.

---
 rtl/mmio_lcl_sequencer_if.sv | 45 ++++
 rtl/mmio_lcl_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mmio_lcl_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_lcl_sequencer_if.sv
// Host request/response channels and local MMIO bus of the MMIO sequencer.
// Handshake rule for host_req and host_rsp: a transfer occurs at a rising clk edge where
// valid && ready are both high; valid and payload stay stable until that edge.
interface mmio_lcl_sequencer_if;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_wr;
  logic        host_req_dw;
  logic [31:0] host_req_addr;
  logic [63:0] host_req_wdata;

  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [63:0] host_rsp_rdata;
  logic        host_rsp_err;

  logic        lcl_mmio_wr;
  logic        lcl_mmio_rd;
  logic [31:0] lcl_mmio_addr;
  logic [31:0] lcl_mmio_din;
  logic        lcl_mmio_ack;
  logic        lcl_mmio_dv;
  logic        lcl_mmio_rsp;
  logic [31:0] lcl_mmio_dout;

  // Sequencer side.
  modport slave (
    input  host_req_valid, host_req_wr, host_req_dw, host_req_addr, host_req_wdata,
    output host_req_ready,
    output host_rsp_valid, host_rsp_rdata, host_rsp_err,
    input  host_rsp_ready,
    output lcl_mmio_wr, lcl_mmio_rd, lcl_mmio_addr, lcl_mmio_din,
    input  lcl_mmio_ack, lcl_mmio_dv, lcl_mmio_rsp, lcl_mmio_dout
  );

  // Host and local-bus environment side.
  modport master (
    output host_req_valid, host_req_wr, host_req_dw, host_req_addr, host_req_wdata,
    input  host_req_ready,
    input  host_rsp_valid, host_rsp_rdata, host_rsp_err,
    output host_rsp_ready,
    input  lcl_mmio_wr, lcl_mmio_rd, lcl_mmio_addr, lcl_mmio_din,
    output lcl_mmio_ack, lcl_mmio_dv, lcl_mmio_rsp, lcl_mmio_dout
  );
endinterface

// File: rtl/mmio_lcl_sequencer.sv
// Splits 4/8-byte host MMIO requests into 32-bit local accesses and merges their
// completions (with per-access timeout) into one registered host response.
module mmio_lcl_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       resetn,
  mmio_lcl_sequencer_if.slave        bus,
  output logic [7:0]                 timeout_cnt,
  output logic [1:0]                 dbg_state
);
  localparam int unsigned     WCW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           wr_q, wr_d;
  logic           dw_q, dw_d;
  logic           half_q, half_d;
  logic           err_q, err_d;
  logic [31:0]    addr_q, addr_d;
  logic [63:0]    wdata_q, wdata_d;
  logic [63:0]    rdata_q, rdata_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [7:0]     tcnt_q, tcnt_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           lwr_q, lwr_d;
  logic           lrd_q, lrd_d;
  logic [31:0]    laddr_q, laddr_d;
  logic [31:0]    ldin_q, ldin_d;

  logic           accept;
  logic           misaligned;
  logic           done;

  assign accept     = bus.host_req_valid && req_ready_q;
  assign misaligned = bus.host_req_dw ? (bus.host_req_addr[2:0] != 3'd0)
                                      : (bus.host_req_addr[1:0] != 2'd0);
  // Only the pulse matching the access direction counts as completion.
  assign done       = wr_q ? bus.lcl_mmio_ack : bus.lcl_mmio_dv;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    dw_d        = dw_q;
    half_d      = half_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    lwr_d       = 1'b0;
    lrd_d       = 1'b0;
    laddr_d     = laddr_q;
    ldin_d      = ldin_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = bus.host_req_wr;
          dw_d    = bus.host_req_dw;
          addr_d  = bus.host_req_addr;
          wdata_d = bus.host_req_wdata;
          rdata_d = '0;
          half_d  = 1'b0;
          err_d   = misaligned;
          state_d = misaligned ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          if (!bus.lcl_mmio_rsp) err_d = 1'b1;
          // Read data is kept even when the status reports a failure.
          if (!wr_q) begin
            if (half_q) rdata_d[63:32] = bus.lcl_mmio_dout;
            else        rdata_d[31:0]  = bus.lcl_mmio_dout;
          end
          if (dw_q && !half_q) begin
            half_d  = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = RESP;
          end
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      RESP: begin
        if (bus.host_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobe, address and data are registered on entry to ISSUE so they are high during it.
    if (state_d == ISSUE) begin
      lwr_d   = wr_d;
      lrd_d   = ~wr_d;
      laddr_d = addr_d + {29'd0, half_d, 2'b00};
      ldin_d  = half_d ? wdata_d[63:32] : wdata_d[31:0];
    end
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q        <= 1'b0;
      dw_q        <= 1'b0;
      half_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      lwr_q       <= 1'b0;
      lrd_q       <= 1'b0;
      laddr_q     <= '0;
      ldin_q      <= '0;
    end else begin
      wr_q        <= wr_d;
      dw_q        <= dw_d;
      half_q      <= half_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      lwr_q       <= lwr_d;
      lrd_q       <= lrd_d;
      laddr_q     <= laddr_d;
      ldin_q      <= ldin_d;
    end
  end

  assign bus.host_req_ready = req_ready_q;
  assign bus.host_rsp_valid = rsp_valid_q;
  assign bus.host_rsp_rdata = rdata_q;
  assign bus.host_rsp_err   = err_q;
  assign bus.lcl_mmio_wr    = lwr_q;
  assign bus.lcl_mmio_rd    = lrd_q;
  assign bus.lcl_mmio_addr  = laddr_q;
  assign bus.lcl_mmio_din   = ldin_q;
  assign timeout_cnt        = tcnt_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_mmio_lcl_sequencer.sv
// Randomized bench for mmio_lcl_sequencer: a local-bus responder follows per-access plans and a
// request-level model predicts strobes, response data/error, timeout count and response timing.
module tb_mmio_lcl_sequencer;
  localparam int TC    = 16;
  localparam int RSP_W = 105;  // {rdata[63:0], err, tcnt[7:0], rise_cycle[31:0]}

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
  } lcl_t;

  typedef struct packed {
    logic [7:0]  lat;    // cycles from strobe to completion pulse
    logic        drop;   // never complete, so the access times out
    logic        rsp;
    logic [31:0] dout;
    logic        wrong;  // also pulse the opposite completion signal early
    logic        late;   // dropped access: pulse completion long after the timeout
  } plan_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] timeout_cnt;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [RSP_W-1:0] exp_q[$];
  lcl_t             exp_lcl[$];
  plan_t            plan_q[$];
  logic [31:0]      seen_addr[$];
  logic [31:0]      seen_din[$];

  logic [7:0]  tcnt_m = 8'd0;
  logic        busy = 1'b0;
  logic        chk_en = 1'b0;
  logic        rdy_force_low = 1'b0;
  logic [63:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_rise = 0;
  int          last_acc = 0;

  mmio_lcl_sequencer_if bus();

  mmio_lcl_sequencer #(.TIMEOUT_CYCLES(TC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .timeout_cnt (timeout_cnt),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic plan_t mk(input int lat, input logic drop, input logic rsp,
                               input logic [31:0] dout, input logic wrong, input logic late);
    plan_t p;
    p.lat = 8'(lat); p.drop = drop; p.rsp = rsp; p.dout = dout; p.wrong = wrong; p.late = late;
    return p;
  endfunction

  function automatic plan_t rnd_plan();
    plan_t p;
    p.lat   = ($urandom_range(0, 9) == 0) ? 8'(TC) : 8'($urandom_range(1, 5));
    p.drop  = ($urandom_range(0, 11) == 0);
    p.rsp   = ($urandom_range(0, 4) != 0);
    p.dout  = $urandom;
    p.wrong = 1'($urandom_range(0, 1));
    p.late  = 1'b0;
    return p;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    chk_en = 1'b0;
    resetn = 1'b0;
    bus.host_req_valid = 1'b0;
    exp_q.delete(); exp_lcl.delete(); plan_q.delete();
    busy = 1'b0;
    tcnt_m = 8'd0;
    @(negedge clk);
    check("reset_host", {bus.host_req_ready, bus.host_rsp_valid, bus.host_rsp_rdata, bus.host_rsp_err}, 0);
    check("reset_lcl", {bus.lcl_mmio_wr, bus.lcl_mmio_rd, bus.lcl_mmio_addr, bus.lcl_mmio_din,
                        timeout_cnt, dbg_state}, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("ready_at_release", bus.host_req_ready, 0);
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  // Model: predicts the local accesses and the merged response of one request.
  task automatic do_req(input logic wr, input logic dw, input logic [31:0] addr,
                        input logic [63:0] wdata, input plan_t p0, input plan_t p1);
    logic        mis;
    logic [63:0] rd;
    logic        err;
    int          lat_sum;
    int          n;
    int          i;
    plan_t       p;
    mis = dw ? (addr[2:0] != 3'd0) : (addr[1:0] != 2'd0);
    rd = '0; err = mis; lat_sum = 0;
    n = mis ? 0 : (dw ? 2 : 1);
    for (int h = 0; h < n; h++) begin
      p = (h == 0) ? p0 : p1;
      exp_lcl.push_back({wr, addr + 32'(4 * h), wdata[32*h +: 32]});
      plan_q.push_back(p);
      if (p.drop) begin
        err = 1'b1;
        rd = '1;
        if (tcnt_m != 8'hFF) tcnt_m++;
        lat_sum += 1 + TC;
        break;
      end
      if (!p.rsp) err = 1'b1;
      if (!wr) rd[32*h +: 32] = p.dout;
      lat_sum += 1 + int'(p.lat);
    end
    @(posedge clk); #1;
    bus.host_req_valid = 1'b1;
    bus.host_req_wr    = wr;
    bus.host_req_dw    = dw;
    bus.host_req_addr  = addr;
    bus.host_req_wdata = wdata;
    i = 0;
    while (i < 3000) begin
      @(negedge clk);
      if (bus.host_req_ready) break;
      i++;
    end
    check("req_accept_bound", i < 3000, 1);
    last_acc = cyc;
    exp_q.push_back({rd, err, tcnt_m, 32'(cyc + 1 + lat_sum)});
    @(posedge clk); #1;
    bus.host_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_bound", n < 3000, 1);
    @(posedge clk); #1;
  endtask

  task automatic lcl_drive(input logic ack, input logic dv, input logic rsp, input logic [31:0] dout);
    bus.lcl_mmio_ack  = ack;
    bus.lcl_mmio_dv   = dv;
    bus.lcl_mmio_rsp  = rsp;
    bus.lcl_mmio_dout = dout;
  endtask

  // Local-bus responder
  initial begin : responder
    plan_t p;
    logic  is_wr;
    lcl_drive(0, 0, 0, 0);
    forever begin
      @(negedge clk);
      if (resetn && (bus.lcl_mmio_wr || bus.lcl_mmio_rd) && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        is_wr = bus.lcl_mmio_wr;
        if (p.drop) begin
          if (p.wrong) begin
            @(posedge clk); #1 lcl_drive(!is_wr, is_wr, 1'b1, $urandom);
            @(posedge clk); #1 lcl_drive(0, 0, 0, 0);
          end
          if (p.late) begin
            repeat (TC + 4) @(posedge clk);
            #1 lcl_drive(is_wr, !is_wr, 1'b0, $urandom);
            @(posedge clk); #1 lcl_drive(0, 0, 0, 0);
          end
        end else begin
          for (int i = 1; i < int'(p.lat); i++) begin
            @(posedge clk); #1;
            if (i == 1 && p.wrong) lcl_drive(!is_wr, is_wr, !p.rsp, $urandom);
            else                   lcl_drive(0, 0, 0, 0);
          end
          @(posedge clk); #1 lcl_drive(is_wr, !is_wr, p.rsp, p.dout);
          @(posedge clk); #1 lcl_drive(0, 0, 0, 0);
        end
      end
    end
  end

  // Host response backpressure
  initial begin : rsp_ready_drv
    bus.host_rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.host_rsp_ready = rdy_force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: compares every cycle against the model's queues
  initial begin : compare
    logic [RSP_W-1:0] e;
    lcl_t             l;
    logic             pv;
    logic [63:0]      prd;
    logic             perr;
    pv = 1'b0; prd = '0; perr = 1'b0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        pv = 1'b0;
      end else begin
        if (bus.lcl_mmio_wr || bus.lcl_mmio_rd) begin
          check("strobe_exclusive", bus.lcl_mmio_wr & bus.lcl_mmio_rd, 0);
          seen_addr.push_back(bus.lcl_mmio_addr);
          seen_din.push_back(bus.lcl_mmio_din);
          if (exp_lcl.size() == 0) begin
            check("strobe_unexpected", 1, 0);
          end else begin
            l = exp_lcl.pop_front();
            check("strobe_dir", bus.lcl_mmio_wr, l.wr);
            check("lcl_addr", bus.lcl_mmio_addr, l.addr);
            check("lcl_din", bus.lcl_mmio_din, l.din);
          end
        end
        check("req_ready", bus.host_req_ready, !busy);
        if (bus.host_rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q[0];
            if (!pv) begin
              check("rsp_time", cyc, e[31:0]);
              last_rise = cyc;
            end else begin
              check("rsp_hold_rdata", bus.host_rsp_rdata, prd);
              check("rsp_hold_err", bus.host_rsp_err, perr);
            end
            if (bus.host_rsp_ready) begin
              e = exp_q.pop_front();
              check("rsp_rdata", bus.host_rsp_rdata, e[104:41]);
              check("rsp_err", bus.host_rsp_err, e[40]);
              check("timeout_cnt", timeout_cnt, e[39:32]);
              last_rdata = bus.host_rsp_rdata;
              last_err   = bus.host_rsp_err;
              busy = 1'b0;
            end
          end
        end
        if (bus.host_req_valid && bus.host_req_ready) busy = 1'b1;
        pv   = bus.host_rsp_valid && !bus.host_rsp_ready;
        prd  = bus.host_rsp_rdata;
        perr = bus.host_rsp_err;
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Main stimulus
  initial begin : main
    logic        wr;
    logic        dw;
    logic [31:0] a;
    bus.host_req_valid = 1'b0;
    bus.host_req_wr    = 1'b0;
    bus.host_req_dw    = 1'b0;
    bus.host_req_addr  = '0;
    bus.host_req_wdata = '0;
    apply_reset();

    // 4-byte write, completion 3 cycles after the strobe
    seen_addr.delete(); seen_din.delete();
    do_req(1'b1, 1'b0, 32'h100, 64'h0000_0000_DEAD_BEEF, mk(3, 0, 1, 0, 0, 0), mk(1, 0, 1, 0, 0, 0));
    wait_idle();
    check("w4_nstrobe", seen_addr.size(), 1);
    check("w4_addr", seen_addr[0], 32'h100);
    check("w4_din", seen_din[0], 32'hDEAD_BEEF);
    check("w4_latency", last_rise - last_acc, 5);
    check("w4_err", last_err, 0);
    check("w4_rdata", last_rdata, 0);

    // 8-byte read, two halves
    seen_addr.delete(); seen_din.delete();
    do_req(1'b0, 1'b1, 32'h208, 64'h0, mk(2, 0, 1, 32'h1111_1111, 0, 0), mk(2, 0, 1, 32'h2222_2222, 0, 0));
    wait_idle();
    check("r8_nstrobe", seen_addr.size(), 2);
    check("r8_addr_lo", seen_addr[0], 32'h208);
    check("r8_addr_hi", seen_addr[1], 32'h20C);
    check("r8_rdata", last_rdata, 64'h2222_2222_1111_1111);
    check("r8_err", last_err, 0);
    check("r8_latency", last_rise - last_acc, 7);

    // 8-byte write, bad status on the high half
    seen_addr.delete(); seen_din.delete();
    do_req(1'b1, 1'b1, 32'h300, 64'hCAFE_F00D_1234_5678, mk(1, 0, 1, 0, 0, 0), mk(2, 0, 0, 0, 0, 0));
    wait_idle();
    check("w8_nstrobe", seen_addr.size(), 2);
    check("w8_addr_hi", seen_addr[1], 32'h304);
    check("w8_din_hi", seen_din[1], 32'hCAFE_F00D);
    check("w8_err", last_err, 1);

    // Read that never completes; its late dv arrives after the timeout
    do_req(1'b0, 1'b0, 32'h40, 64'h0, mk(1, 1, 1, 0, 0, 1), mk(1, 0, 1, 0, 0, 0));
    wait_idle();
    check("to_latency", last_rise - last_acc, 18);
    check("to_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_err", last_err, 1);
    repeat (TC + 10) @(posedge clk);
    #1;
    check("to_cnt", timeout_cnt, 1);
    check("stray_no_rsp", bus.host_rsp_valid, 0);
    check("stray_ready", bus.host_req_ready, 1);

    // Misaligned 8-byte request with the response held off
    seen_addr.delete(); seen_din.delete();
    rdy_force_low = 1'b1;
    do_req(1'b1, 1'b1, 32'h104, 64'h1, mk(1, 0, 1, 0, 0, 0), mk(1, 0, 1, 0, 0, 0));
    repeat (5) @(negedge clk);
    check("mis_valid_held", bus.host_rsp_valid, 1);
    check("mis_ready_low", bus.host_req_ready, 0);
    rdy_force_low = 1'b0;
    wait_idle();
    check("mis_nstrobe", seen_addr.size(), 0);
    check("mis_latency", last_rise - last_acc, 1);
    check("mis_err", last_err, 1);

    // Reset while waiting for a local completion, then a normal request
    do_req(1'b0, 1'b0, 32'h400, 64'h0, mk(1, 1, 1, 0, 0, 0), mk(1, 0, 1, 0, 0, 0));
    repeat (3) @(posedge clk);
    apply_reset();
    do_req(1'b1, 1'b0, 32'h500, 64'h55AA, mk(2, 0, 1, 0, 0, 0), mk(1, 0, 1, 0, 0, 0));
    wait_idle();
    check("post_reset_err", last_err, 0);
    check("post_reset_latency", last_rise - last_acc, 4);

    // Random back-to-back traffic
    for (int t = 0; t < 150; t++) begin
      wr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 7) != 0) a[2:0] = dw ? 3'd0 : {a[2], 2'b00};
      do_req(wr, dw, a, {$urandom, $urandom}, rnd_plan(), rnd_plan());
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
